// File: rtl/gpio_pkg.sv
// gpio_pkg: pin mode encodings and limits shared by the GPIO register block and pad frontend.
package gpio_pkg;
  typedef enum logic [1:0] {
    GPIO_MODE_HIZ = 2'b00,
    GPIO_MODE_OUT = 2'b01,
    GPIO_MODE_IN  = 2'b10,
    GPIO_MODE_RSV = 2'b11
  } gpio_mode_e;
  localparam int GPIO_MAX_IO = 16;
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one pin's two-flop synchronizer, debounce filter and edge detect.
// GPIO_PAD_DEBOUNCE_EN selects the filtered path; otherwise the synchronizer output is used directly.
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic pad_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);
  logic s1_q, s2_q, prev_q;
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("gpio_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= pad_i;
      s2_q   <= s1_q;
      prev_q <= stable_o;
    end
  end
`ifdef GPIO_PAD_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Count only while the synchronized input disagrees; any agreement restarts the window.
  always_comb begin
    stable_d = (s2_q != stable_q && cnt_q == CNT_MAX) ? s2_q : stable_q;
    cnt_d    = (s2_q == stable_q || cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end
  assign stable_o = stable_q;
`else
  assign stable_o = s2_q;
`endif
  assign rise_o = stable_o & ~prev_q;
  assign fall_o = ~stable_o & prev_q;
endmodule

// File: rtl/gpio_pad_frontend.sv
// gpio_pad_frontend: pad-side mode decode, registered outputs, filtered inputs and sticky edge interrupts.
// Input filtering is chosen by GPIO_PAD_DEBOUNCE_EN (see gpio_debounce).
module gpio_pad_frontend
  import gpio_pkg::*;
#(
  parameter int NUM_IO          = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       reg_ctrl_i,
  input  logic [31:0]       reg_data_i,
  input  logic [NUM_IO-1:0] pad_in_i,
  output logic [NUM_IO-1:0] pad_out_o,
  output logic [NUM_IO-1:0] pad_oe_o,
  output logic [NUM_IO-1:0] io_pin_o,
  input  logic [NUM_IO-1:0] irq_rise_en_i,
  input  logic [NUM_IO-1:0] irq_fall_en_i,
  input  logic [NUM_IO-1:0] irq_clr_i,
  output logic [NUM_IO-1:0] irq_pend_o,
  output logic              irq_o
);
  logic [NUM_IO-1:0] oe_q, oe_d, out_q, out_d, pend_q, pend_d;
  logic [NUM_IO-1:0] stable, rise, fall, irq_set;
  logic              unused_hi_bits;
  if (NUM_IO < 1 || NUM_IO > GPIO_MAX_IO) begin : g_bad_cfg
    $error("gpio_pad_frontend: NUM_IO must be 1..GPIO_MAX_IO");
  end
  for (genvar i = 0; i < NUM_IO; i++) begin : g_pin
    gpio_mode_e mode;
    assign mode       = gpio_mode_e'(reg_ctrl_i[2*i +: 2]);
    assign oe_d[i]    = mode == GPIO_MODE_OUT;
    assign out_d[i]   = oe_d[i] & reg_data_i[i];
    assign irq_set[i] = mode == GPIO_MODE_IN &&
                        ((rise[i] & irq_rise_en_i[i]) | (fall[i] & irq_fall_en_i[i]));
    gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk      (clk),
      .rstn     (rstn),
      .pad_i    (pad_in_i[i]),
      .stable_o (stable[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i])
    );
  end
  // A new edge outranks a simultaneous clear so no event is lost.
  assign pend_d = (pend_q & ~irq_clr_i) | irq_set;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      oe_q   <= '0;
      out_q  <= '0;
      pend_q <= '0;
    end else begin
      oe_q   <= oe_d;
      out_q  <= out_d;
      pend_q <= pend_d;
    end
  end
  assign pad_oe_o       = oe_q;
  assign pad_out_o      = out_q;
  assign io_pin_o       = stable;
  assign irq_pend_o     = pend_q;
  assign irq_o          = |pend_q;
  assign unused_hi_bits = ^{reg_ctrl_i, reg_data_i};
endmodule

// File: tb/tb_gpio_pad_frontend.sv
// tb_gpio_pad_frontend: directed scenarios plus randomized traffic checked against a history-based model.
module tb_gpio_pad_frontend;
  localparam int N = 2;
  localparam int D = 16;
`ifdef GPIO_PAD_DEBOUNCE_EN
  localparam int LAT = 2 + D;
`else
  localparam int LAT = 2;
`endif
  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   ctrl, data;
  logic [N-1:0]  pad, ren, fen, clr;
  logic [N-1:0]  pad_out_o, pad_oe_o, io_pin_o, irq_pend_o;
  logic          irq_o;
  int            vectors = 0;
  int            miscompares = 0;
  logic [N-1:0]  m_oe, m_out, m_st, m_pv, m_pend;
  logic [N-1:0]  hist[$];

  gpio_pad_frontend #(.NUM_IO(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .reg_ctrl_i    (ctrl),
    .reg_data_i    (data),
    .pad_in_i      (pad),
    .pad_out_o     (pad_out_o),
    .pad_oe_o      (pad_oe_o),
    .io_pin_o      (io_pin_o),
    .irq_rise_en_i (ren),
    .irq_fall_en_i (fen),
    .irq_clr_i     (clr),
    .irq_pend_o    (irq_pend_o),
    .irq_o         (irq_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_oe = '0; m_out = '0; m_st = '0; m_pv = '0; m_pend = '0;
    hist.delete();
    repeat (2 + D) hist.push_back('0);
  endtask

  // hist holds one pad sample per clock edge; the pin value seen by the filter lags two samples.
  task automatic model_edge();
    logic [N-1:0] set_v;
    logic [1:0]   mode;
    logic         flip;
    if (!rstn) begin
      model_reset();
      return;
    end
    set_v = '0;
    for (int i = 0; i < N; i++) begin
      mode = ctrl[2*i +: 2];
      set_v[i] = (mode == 2'b10) && ((m_st[i] && !m_pv[i] && ren[i]) || (!m_st[i] && m_pv[i] && fen[i]));
      m_oe[i]  = (mode == 2'b01);
      m_out[i] = m_oe[i] & data[i];
    end
    m_pend = (m_pend & ~clr) | set_v;
    m_pv   = m_st;
`ifdef GPIO_PAD_DEBOUNCE_EN
    for (int i = 0; i < N; i++) begin
      flip = 1'b1;
      for (int k = 0; k < D; k++)
        if (hist[hist.size() - 2 - k][i] == m_st[i]) flip = 1'b0;
      if (flip) m_st[i] = ~m_st[i];
    end
`else
    m_st = hist[hist.size() - 1];
`endif
    hist.push_back(pad);
    void'(hist.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; pad = '1; ctrl = 32'h5; data = '1; ren = '1; fen = '1; clr = '0;
    repeat (3) begin
      step();
      vectors++;
      if ({pad_oe_o, pad_out_o, io_pin_o, irq_pend_o, irq_o} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: got %b required 0", {pad_oe_o, pad_out_o, io_pin_o, irq_pend_o, irq_o});
      end
    end
    rstn = 1'b1; ctrl = '0; ren = '0; fen = '0;
    repeat (LAT - 1) step();
    vectors++;
    if (io_pin_o !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_io_early: got %b required 00", io_pin_o);
    end
    step();
    vectors++;
    if (io_pin_o !== 2'b11 || io_pin_o !== m_st) begin
      miscompares++;
      $display("FAIL reset_io_latency: got %b required 11 (model %b)", io_pin_o, m_st);
    end
  endtask

  task automatic test_output();
    ctrl = 32'h5; data = 32'h2;
    step();
    vectors++;
    if (pad_oe_o !== 2'b11 || pad_out_o !== 2'b10) begin
      miscompares++;
      $display("FAIL out_drive: got oe=%b out=%b required oe=11 out=10", pad_oe_o, pad_out_o);
    end
    ctrl = 32'h0;
    step();
    vectors++;
    if (pad_oe_o !== 2'b00 || pad_out_o !== 2'b00) begin
      miscompares++;
      $display("FAIL out_hiz: got oe=%b out=%b required 00/00", pad_oe_o, pad_out_o);
    end
    ctrl = 32'hFFFF_FFF7; data = '1;
    step();
    vectors++;
    if (pad_oe_o !== 2'b10 || pad_out_o !== 2'b10) begin
      miscompares++;
      $display("FAIL out_reserved: got oe=%b out=%b required oe=10 out=10", pad_oe_o, pad_out_o);
    end
    for (int c = 0; c < 20; c++) begin
      ctrl = $urandom; data = $urandom;
      step();
      vectors++;
      if (pad_oe_o !== m_oe || pad_out_o !== m_out) begin
        miscompares++;
        $display("FAIL out_random: ctrl=%h data=%h got oe=%b out=%b required oe=%b out=%b",
                 ctrl, data, pad_oe_o, pad_out_o, m_oe, m_out);
      end
    end
    ctrl = '0;
  endtask

  task automatic test_debounce();
    int n;
    pad = '0;
    repeat (LAT + 2) step();
    vectors++;
    if (io_pin_o !== 2'b00) begin
      miscompares++;
      $display("FAIL deb_settle: got %b required 00", io_pin_o);
    end
    for (int c = 0; c < 15; c++) begin
      pad[0] = ~pad[0];
      step();
      vectors++;
      if (io_pin_o !== m_st) begin
        miscompares++;
        $display("FAIL deb_glitch: got %b required %b", io_pin_o, m_st);
      end
    end
    pad[0] = 1'b0;
    repeat (LAT + 2) begin
      step();
      vectors++;
      if (io_pin_o !== m_st) begin
        miscompares++;
        $display("FAIL deb_return: got %b required %b", io_pin_o, m_st);
      end
`ifdef GPIO_PAD_DEBOUNCE_EN
      vectors++;
      if (io_pin_o[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL deb_filtered: got %b required 0", io_pin_o[0]);
      end
`endif
    end
    pad[0] = 1'b1;
    n = 0;
    while (io_pin_o[0] !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    vectors++;
    if (n != LAT) begin
      miscompares++;
      $display("FAIL deb_step_latency: got %0d cycles required %0d", n, LAT);
    end
  endtask

  task automatic test_irq();
    int n;
    ctrl = 32'hA; ren = 2'b01; fen = 2'b00; pad = '0;
    repeat (LAT + 2) step();
    clr = '1;
    step();
    clr = '0;
    vectors++;
    if (irq_pend_o !== 2'b00 || irq_o !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_idle: got pend=%b irq=%b required 00/0", irq_pend_o, irq_o);
    end
    pad[0] = 1'b1;
    n = 0;
    while (io_pin_o[0] !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    vectors++;
    if (n != LAT || irq_pend_o !== 2'b00) begin
      miscompares++;
      $display("FAIL irq_before_set: got %0d cycles pend=%b required %0d cycles pend=00", n, irq_pend_o, LAT);
    end
    step();
    vectors++;
    if (irq_pend_o !== 2'b01 || irq_o !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_rise_set: got pend=%b irq=%b required 01/1", irq_pend_o, irq_o);
    end
    pad[1] = 1'b1;
    repeat (LAT + 3) step();
    vectors++;
    if (irq_pend_o !== 2'b01 || io_pin_o !== 2'b11) begin
      miscompares++;
      $display("FAIL irq_rise_disabled: got pend=%b io=%b required pend=01 io=11", irq_pend_o, io_pin_o);
    end
  endtask

  task automatic test_clear_race();
    int n;
    fen = 2'b01; pad[0] = 1'b0;
    n = 0;
    while (io_pin_o[0] !== 1'b0 && n < 60) begin
      step();
      n++;
    end
    clr = 2'b01;
    step();
    clr = '0;
    vectors++;
    if (n != LAT || irq_pend_o[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_race: got %0d cycles pend0=%b required %0d cycles pend0=1", n, irq_pend_o[0], LAT);
    end
    repeat (2) step();
    clr = 2'b01;
    step();
    clr = '0;
    vectors++;
    if (irq_pend_o !== 2'b00 || irq_o !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_lone: got pend=%b irq=%b required 00/0", irq_pend_o, irq_o);
    end
  endtask

  task automatic test_mode_switch();
    ctrl = 32'h0; ren = '1; fen = '0; pad = 2'b01;
    repeat (LAT + 3) step();
    ctrl = 32'hA;
    repeat (4) begin
      step();
      vectors++;
      if (irq_pend_o !== 2'b00 || io_pin_o !== 2'b01) begin
        miscompares++;
        $display("FAIL mode_switch: got pend=%b io=%b required pend=00 io=01", irq_pend_o, io_pin_o);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) pad[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) ctrl = $urandom;
      if ($urandom_range(0, 15) == 0) begin
        ren = N'($urandom);
        fen = N'($urandom);
      end
      data = $urandom;
      clr  = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      rstn = ($urandom_range(0, 499) != 0);
      step();
      vectors++;
      if ({pad_oe_o, pad_out_o, io_pin_o, irq_pend_o, irq_o} !== {m_oe, m_out, m_st, m_pend, |m_pend}) begin
        miscompares++;
        $display("FAIL random cyc %0d: got oe=%b out=%b io=%b pend=%b irq=%b required oe=%b out=%b io=%b pend=%b irq=%b",
                 c, pad_oe_o, pad_out_o, io_pin_o, irq_pend_o, irq_o, m_oe, m_out, m_st, m_pend, |m_pend);
      end
    end
    rstn = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_output();
    test_debounce();
    test_irq();
    test_clear_race();
    test_mode_switch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
